// File: rtl/jtframe_dmacopy_pkg.sv
// ============================================================================
// jtframe_dmacopy_pkg
// Shared FSM state encoding and default widths for the 68000 DMA copy engine.
// Revision: 1.0
// ============================================================================
`default_nettype none

package jtframe_dmacopy_pkg;

  localparam int AW_DEF = 23;
  localparam int LW_DEF = 12;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    REL   = 3'd4
  } dma_state_e;

endpackage

`default_nettype wire

// File: rtl/jtframe_dmacopy.sv
// ============================================================================
// jtframe_dmacopy
// Bus-master word copy engine: requests the 68000 bus, copies len words from
// src to dst, then releases the bus.
// Revision: 1.0
// ============================================================================
`default_nettype none

module jtframe_dmacopy
  import jtframe_dmacopy_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [LW-1:0] len,
  output logic          dev_br,
  input  logic          cpu_BGACKn,
  output logic [AW-1:0] bus_addr,
  output logic [15:0]   bus_dout,
  input  logic [15:0]   bus_din,
  output logic          bus_rd,
  output logic          bus_wr,
  input  logic          bus_ack,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [AW-1:0] C_ONE_A = AW'(1);
  localparam logic [LW-1:0] C_ONE_L = LW'(1);

  dma_state_e    state_q;
  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic [LW-1:0] cnt_q;
  logic          abort_q;

  logic [AW-1:0] src_d;
  logic [AW-1:0] dst_d;
  logic [LW-1:0] cnt_d;
  logic          stop_d;

  assign src_d  = src_q + C_ONE_A;
  assign dst_d  = dst_q + C_ONE_A;
  assign cnt_d  = cnt_q - C_ONE_L;
  // Abort is only acted on after the word in flight has been written.
  assign stop_d = (cnt_d == '0) || abort_q || abort;
  assign busy   = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      cnt_q    <= '0;
      abort_q  <= 1'b0;
      dev_br   <= 1'b0;
      bus_addr <= '0;
      bus_dout <= '0;
      bus_rd   <= 1'b0;
      bus_wr   <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cen) begin
        if (state_q != IDLE && abort) begin
          abort_q <= 1'b1;
        end
        unique case (state_q)
          IDLE: begin
            if (start) begin
              if (len != '0) begin
                src_q   <= src_addr;
                dst_q   <= dst_addr;
                cnt_q   <= len;
                abort_q <= 1'b0;
                err     <= 1'b0;
                dev_br  <= 1'b1;
                state_q <= REQ;
              end else begin
                done <= 1'b1;
              end
            end
          end
          REQ: begin
            if (abort || abort_q) begin
              dev_br  <= 1'b0;
              state_q <= REL;
            end else if (!cpu_BGACKn) begin
              bus_addr <= src_q;
              bus_rd   <= 1'b1;
              state_q  <= READ;
            end
          end
          READ: begin
            if (cpu_BGACKn) begin
              bus_rd  <= 1'b0;
              err     <= 1'b1;
              dev_br  <= 1'b0;
              done    <= 1'b1;
              state_q <= IDLE;
            end else if (bus_ack) begin
              bus_dout <= bus_din;
              bus_rd   <= 1'b0;
              bus_addr <= dst_q;
              bus_wr   <= 1'b1;
              state_q  <= WRITE;
            end
          end
          WRITE: begin
            if (cpu_BGACKn) begin
              bus_wr  <= 1'b0;
              err     <= 1'b1;
              dev_br  <= 1'b0;
              done    <= 1'b1;
              state_q <= IDLE;
            end else if (bus_ack) begin
              bus_wr <= 1'b0;
              src_q  <= src_d;
              dst_q  <= dst_d;
              cnt_q  <= cnt_d;
              if (stop_d) begin
                dev_br  <= 1'b0;
                state_q <= REL;
              end else begin
                bus_addr <= src_d;
                bus_rd   <= 1'b1;
                state_q  <= READ;
              end
            end
          end
          REL: begin
            if (cpu_BGACKn) begin
              done    <= 1'b1;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/jtframe_dmacopy.md
# jtframe_dmacopy

Bus-master copy engine for 68000-based cores. It sits directly downstream of the 68000 bus arbiter: it raises the arbiter's bus request, waits for the arbiter to take the bus (BGACKn low), and then copies a block of 16-bit words from a source address to a destination address on the shared bus. When the copy ends it releases the request. Typical uses are sprite-list and palette copies triggered by a CPU register write.

## Interface
Parameters:
- AW, 23: word address width (68000 A23..A1).
- LW, 12: width of the word-count field.

Ports:
- clk  in  1  system clock
- rst  in  1  reset. Asynchronous, active-high.
- cen  in  1  clock enable. The FSM advances only on clk edges with cen=1.
- start  in  1  copy request, sampled on a cen edge. Ignored while busy.
- abort  in  1  requests an early stop, sampled on a cen edge.
- src_addr  in  AW  source word address, latched at start.
- dst_addr  in  AW  destination word address, latched at start.
- len  in  LW  number of words to copy, latched at start.
- dev_br  out  1  bus request to the arbiter (high = request).
- cpu_BGACKn  in  1  arbiter's bus-grant-acknowledge. Low means this block owns the bus.
- bus_addr  out  AW  master word address.
- bus_dout  out  16  write data.
- bus_din  in  16  read data, valid when bus_ack=1.
- bus_rd  out  1  read strobe.
- bus_wr  out  1  write strobe.
- bus_ack  in  1  memory ready for the current strobe.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-clk pulse when a copy ends, whether normal or aborted.
- err  out  1  sticky flag: bus lost mid-transfer. Cleared by the next accepted start.

## Operation
States: IDLE, REQ, READ, WRITE, REL.

- **IDLE**
  - start=1 and len≠0: latch src, dst and len, set dev_br=1, clear err, go to REQ.
  - start=1 and len=0: no bus request is made. done pulses and the FSM stays in IDLE.
- **REQ**
  - Wait for cpu_BGACKn=0, then go to READ.
  - abort=1 while in REQ: go to REL.
- **READ**
  - Outputs: bus_addr=src, bus_rd=1.
  - On bus_ack=1: latch bus_din into the data register, drop bus_rd, go to WRITE.
- **WRITE**
  - Outputs: bus_addr=dst, bus_dout=data register, bus_wr=1.
  - On bus_ack=1: drop bus_wr, src+=1, dst+=1, count-=1.
  - If the new count is 0, or abort has been seen since the copy started, go to REL. Otherwise go to READ.
- **REL**
  - Set dev_br=0.
  - Wait for cpu_BGACKn=1, then go to IDLE and pulse done.

Rules:
- Abort is held in a sticky flag. It is honoured only at a word boundary: a word already read is always written before the FSM stops.
- Bus loss: if cpu_BGACKn goes high while in READ or WRITE:
  - drop the strobes immediately (same cen edge);
  - set err=1 and dev_br=0;
  - go to IDLE and pulse done.
- Addresses wrap modulo 2^AW. Count arithmetic is LW bits wide.
- start and abort together in IDLE: start is accepted and abort is ignored.
- Reset at any time, including mid-transfer: all outputs go to 0 within the reset assertion and the FSM goes to IDLE.

## Timing
- Reset values: dev_br=0, bus_rd=0, bus_wr=0, bus_addr=0, bus_dout=0, busy=0, done=0, err=0.
- dev_br rises on the same cen edge that accepts start.
- READ starts on the cen edge after cpu_BGACKn=0 is sampled in REQ.
- Each word costs at least 2 cen cycles: one READ and one WRITE, each extended by waiting for bus_ack.
- Minimum copy time with bus_ack tied high and an immediate grant: 1 (REQ) + 2·len + 1 (REL) cen cycles.
- Strobes are registered:
  - they assert on the cen edge that enters READ or WRITE;
  - they deassert on the cen edge that samples bus_ack=1.
- done is set on the cen edge that enters IDLE and cleared on the next clk edge.

## Structure
- Shared package jtframe_dmacopy_pkg holds:
  - the state enum (IDLE, REQ, READ, WRITE, REL);
  - default widths AW_DEF=23 and LW_DEF=12.
- A single module holds the FSM and registers, roughly 150–250 lines. No sub-module is needed.
- Verification pairs this block with the existing 68000 arbiter and a behavioural 68000 bus-grant model.

## Test plan
- **Basic copy:** src=0x100, dst=0x800, len=4, memory preloaded 0xA000..0xA003, bus_ack=1, immediate grant → writes to 0x800..0x803 carry 0xA000..0xA003, done pulses once, dev_br=0 at the end, total 10 cen cycles.
- **Zero length:** len=0 → done pulses, dev_br is never asserted, busy stays 0.
- **Wait states:** bus_ack delayed 3 cen cycles per access, len=2 → the strobes are held until ack and the data are correct.
- **Abort:** len=8, abort raised during the 3rd READ → exactly 3 words are written, then REL and done.
- **Bus loss and reset:** force cpu_BGACKn high in WRITE → strobes drop, err=1, done pulses. Then assert rst during REQ → all outputs return to 0 immediately.
- **Wrap-around:** src=0x7FFFFF (AW=23), len=2 → the second read is from address 0.
